// File: rtl/count_bcd_display_if.sv
// Display-side bus of the BCD display stage: counter value in, converted digits
// and multiplexed 7-segment drive out.
interface count_bcd_display_if;
  logic [7:0]  count;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic        busy;
  logic [6:0]  seg;
  logic [2:0]  an;

  modport master (
    output count,
    input  bcd, bcd_valid, busy, seg, an
  );

  modport slave (
    input  count,
    output bcd, bcd_valid, busy, seg, an
  );
endinterface

// File: rtl/count_bcd_display.sv
// Converts the down counter's value to BCD with a sequential double-dabble engine
// and scans it onto a 3-digit common-anode display with leading-zero blanking.
module count_bcd_display #(
  parameter int SCAN_DIV = 4
) (
  input logic               clk,
  input logic               reset,
  count_bcd_display_if.slave bus
);

  typedef enum logic {IDLE, CONV} state_t;

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  state_t      state;
  logic [7:0]  last;
  logic [7:0]  shreg;
  logic [11:0] scratch;
  logic [2:0]  shift_cnt;
  logic [11:0] bcd_q;
  logic        bcd_valid_q;
  logic        busy_q;

  logic [11:0] adj;
  logic [19:0] shifted;

  logic [SW-1:0] scan_cnt;
  logic [1:0]    digit;
  logic [3:0]    nib;
  logic [2:0]    an_next;
  logic          blank;
  logic [6:0]    seg_q;
  logic [2:0]    an_q;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // Add-3 correction on every nibble that would exceed 9 after the next doubling
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 3; i++) begin
      if (scratch[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
    end
  end

  assign shifted = {adj[10:0], shreg, 1'b0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last        <= 8'h00;
      shreg       <= 8'h00;
      scratch     <= 12'h000;
      shift_cnt   <= 3'd0;
      bcd_q       <= 12'h000;
      bcd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      bcd_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.count != last) begin
            shreg     <= bus.count;
            last      <= bus.count;
            scratch   <= 12'h000;
            shift_cnt <= 3'd0;
            busy_q    <= 1'b1;
            state     <= CONV;
          end
        end
        CONV: begin
          {scratch, shreg} <= shifted;
          shift_cnt        <= shift_cnt + 3'd1;
          if (shift_cnt == 3'd7) begin
            bcd_q       <= shifted[19:8];
            bcd_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      digit    <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      digit    <= (digit == 2'd2) ? 2'd0 : digit + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Slot selection reads only the committed bcd so a partial conversion never shows
  always_comb begin
    nib     = bcd_q[3:0];
    an_next = 3'b110;
    blank   = 1'b0;
    case (digit)
      2'd1: begin
        nib     = bcd_q[7:4];
        an_next = 3'b101;
        blank   = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
      end
      2'd2: begin
        nib     = bcd_q[11:8];
        an_next = 3'b011;
        blank   = (bcd_q[11:8] == 4'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q <= 7'b1111111;
      an_q  <= 3'b111;
    end else if (blank) begin
      seg_q <= 7'b1111111;
      an_q  <= 3'b111;
    end else begin
      seg_q <= decode(nib);
      an_q  <= an_next;
    end
  end

  assign bus.bcd       = bcd_q;
  assign bus.bcd_valid = bcd_valid_q;
  assign bus.busy      = busy_q;
  assign bus.seg       = seg_q;
  assign bus.an        = an_q;

endmodule

// File: tb/tb_count_bcd_display.sv
// Scoreboard bench for count_bcd_display: expected BCD values are queued as the
// count is driven and popped whenever bcd_valid pulses.
module tb_count_bcd_display;
  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  count_bcd_display_if bus();

  count_bcd_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  logic [11:0] mon_exp;
  int valid_count = 0;
  int cycle = 0;
  int last_valid_cycle = 0;
  int prev_valid_cycle = 0;

  function automatic logic [11:0] to_bcd(input int v);
    to_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (reset === 1'b1 && bus.bcd_valid === 1'b1) begin
      valid_count++;
      prev_valid_cycle = last_valid_cycle;
      last_valid_cycle = cycle;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL bcd_pulse: unexpected pulse, got bcd=%h, expected no pulse", bus.bcd);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.bcd !== mon_exp) begin
          errors++;
          $display("[TB] FAIL bcd_value: got %h, expected %h", bus.bcd, mon_exp);
        end
      end
    end
  end

  task automatic wait_pulses(input int target, input int budget, output bit ok);
    int n = 0;
    while (valid_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (valid_count >= target);
  endtask

  // Samples one full scan period and groups what was seen by anode pattern
  task automatic capture_display(output int n_ones, output int n_tens, output int n_hund,
                                 output int n_blank, output logic [6:0] s_ones,
                                 output logic [6:0] s_tens, output logic [6:0] s_hund,
                                 output logic [6:0] s_blank, output int incons);
    n_ones = 0; n_tens = 0; n_hund = 0; n_blank = 0; incons = 0;
    s_ones = 'x; s_tens = 'x; s_hund = 'x; s_blank = 'x;
    for (int i = 0; i < 3 * SCAN_DIV; i++) begin
      @(negedge clk);
      case (bus.an)
        3'b110: begin if (n_ones > 0 && bus.seg !== s_ones) incons++; s_ones = bus.seg; n_ones++; end
        3'b101: begin if (n_tens > 0 && bus.seg !== s_tens) incons++; s_tens = bus.seg; n_tens++; end
        3'b011: begin if (n_hund > 0 && bus.seg !== s_hund) incons++; s_hund = bus.seg; n_hund++; end
        3'b111: begin if (n_blank > 0 && bus.seg !== s_blank) incons++; s_blank = bus.seg; n_blank++; end
        default: incons++;
      endcase
    end
  endtask

  task automatic test_reset();
    int base, k, n;
    bit ok;
    int no, nt, nh, nb, inc;
    logic [6:0] so, st, sh, sb;
    reset = 1'b0;
    bus.count = 8'd255;
    repeat (2) @(negedge clk);
    checks++; if (bus.bcd !== 12'h000) begin errors++; $display("[TB] FAIL reset_bcd: got %h, expected 000", bus.bcd); end
    checks++; if (bus.an !== 3'b111) begin errors++; $display("[TB] FAIL reset_an: got %b, expected 111", bus.an); end
    checks++; if (bus.seg !== 7'b1111111) begin errors++; $display("[TB] FAIL reset_seg: got %b, expected 1111111", bus.seg); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", bus.busy); end
    base = valid_count;
    exp_q.push_back(to_bcd(255));
    reset = 1'b1;
    k = 0;
    while (bus.busy !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    n = 0;
    while (bus.busy === 1'b1 && n < 30) begin n++; @(negedge clk); end
    checks++; if (n != 8) begin errors++; $display("[TB] FAIL busy_length: got %0d cycles, expected 8", n); end
    wait_pulses(base + 1, 20, ok);
    repeat (3) @(negedge clk);
    checks++; if (valid_count - base != 1) begin errors++; $display("[TB] FAIL reset_pulses: got %0d, expected 1", valid_count - base); end
    repeat (3 * SCAN_DIV + 2) @(negedge clk);
    capture_display(no, nt, nh, nb, so, st, sh, sb, inc);
    checks++; if (no != SCAN_DIV || so !== 7'b0010010) begin errors++; $display("[TB] FAIL disp255_ones: got n=%0d seg=%b, expected n=%0d seg=0010010", no, so, SCAN_DIV); end
    checks++; if (nt != SCAN_DIV || st !== 7'b0010010) begin errors++; $display("[TB] FAIL disp255_tens: got n=%0d seg=%b, expected n=%0d seg=0010010", nt, st, SCAN_DIV); end
    checks++; if (nh != SCAN_DIV || sh !== 7'b0100100) begin errors++; $display("[TB] FAIL disp255_hund: got n=%0d seg=%b, expected n=%0d seg=0100100", nh, sh, SCAN_DIV); end
    checks++; if (nb != 0 || inc != 0) begin errors++; $display("[TB] FAIL disp255_blank: got blank=%0d incons=%0d, expected 0 and 0", nb, inc); end
  endtask

  task automatic test_hundred();
    int base, no, nt, nh, nb, inc;
    bit ok;
    logic [6:0] so, st, sh, sb;
    @(negedge clk);
    base = valid_count;
    exp_q.push_back(to_bcd(100));
    bus.count = 8'd100;
    wait_pulses(base + 1, 40, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL hundred_timeout: got no pulse, expected one within 40 cycles"); end
    checks++; if (bus.bcd !== 12'h100) begin errors++; $display("[TB] FAIL hundred_bcd: got %h, expected 100", bus.bcd); end
    repeat (3 * SCAN_DIV + 2) @(negedge clk);
    capture_display(no, nt, nh, nb, so, st, sh, sb, inc);
    checks++; if (nh != SCAN_DIV || sh !== 7'b1111001) begin errors++; $display("[TB] FAIL disp100_hund: got n=%0d seg=%b, expected n=%0d seg=1111001", nh, sh, SCAN_DIV); end
    checks++; if (nt != SCAN_DIV || st !== 7'b1000000) begin errors++; $display("[TB] FAIL disp100_tens: got n=%0d seg=%b, expected n=%0d seg=1000000", nt, st, SCAN_DIV); end
    checks++; if (no != SCAN_DIV || so !== 7'b1000000) begin errors++; $display("[TB] FAIL disp100_ones: got n=%0d seg=%b, expected n=%0d seg=1000000", no, so, SCAN_DIV); end
    checks++; if (nb != 0 || inc != 0) begin errors++; $display("[TB] FAIL disp100_blank: got blank=%0d incons=%0d, expected 0 and 0", nb, inc); end
  endtask

  task automatic test_seven();
    int base, no, nt, nh, nb, inc;
    bit ok;
    logic [6:0] so, st, sh, sb;
    @(negedge clk);
    base = valid_count;
    exp_q.push_back(to_bcd(7));
    bus.count = 8'd7;
    wait_pulses(base + 1, 40, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL seven_timeout: got no pulse, expected one within 40 cycles"); end
    repeat (3 * SCAN_DIV + 2) @(negedge clk);
    capture_display(no, nt, nh, nb, so, st, sh, sb, inc);
    checks++; if (no != SCAN_DIV || so !== 7'b1111000) begin errors++; $display("[TB] FAIL disp7_ones: got n=%0d seg=%b, expected n=%0d seg=1111000", no, so, SCAN_DIV); end
    checks++; if (nb != 2 * SCAN_DIV || sb !== 7'b1111111) begin errors++; $display("[TB] FAIL disp7_blank: got n=%0d seg=%b, expected n=%0d seg=1111111", nb, sb, 2 * SCAN_DIV); end
    checks++; if (nt != 0 || nh != 0 || inc != 0) begin errors++; $display("[TB] FAIL disp7_lit: got tens=%0d hund=%0d incons=%0d, expected 0 0 0", nt, nh, inc); end
  endtask

  task automatic test_back_to_back();
    int base, k;
    bit ok;
    @(negedge clk);
    base = valid_count;
    exp_q.push_back(to_bcd(200));
    bus.count = 8'd200;
    k = 0;
    while (bus.busy !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    @(negedge clk);
    exp_q.push_back(to_bcd(199));
    bus.count = 8'd199;
    wait_pulses(base + 2, 60, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_timeout: got %0d pulses, expected 2", valid_count - base); end
    checks++; if (last_valid_cycle - prev_valid_cycle != 9) begin errors++; $display("[TB] FAIL b2b_period: got %0d cycles, expected 9", last_valid_cycle - prev_valid_cycle); end
    repeat (20) @(negedge clk);
    checks++; if (valid_count - base != 2) begin errors++; $display("[TB] FAIL b2b_pulses: got %0d, expected 2", valid_count - base); end
  endtask

  task automatic test_reset_mid_conv();
    int base, k;
    bit ok;
    @(negedge clk);
    base = valid_count;
    exp_q.push_back(to_bcd(255));
    bus.count = 8'd255;
    k = 0;
    while (bus.busy !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b, expected 0", bus.busy); end
    checks++; if (bus.bcd !== 12'h000) begin errors++; $display("[TB] FAIL abort_bcd: got %h, expected 000", bus.bcd); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_pulses(base + 1, 40, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL abort_reconvert: got no pulse, expected one"); end
    checks++; if (bus.bcd !== 12'h255) begin errors++; $display("[TB] FAIL abort_bcd_after: got %h, expected 255", bus.bcd); end
  endtask

  task automatic test_countdown();
    int base;
    bit ok;
    @(negedge clk);
    reset = 1'b0;
    bus.count = 8'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    base = valid_count;
    repeat (3) @(negedge clk);
    checks++; if (valid_count != base) begin errors++; $display("[TB] FAIL zero_no_conv: got %0d pulses, expected 0", valid_count - base); end
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(to_bcd(255 - i));
      bus.count = 8'(255 - i);
      repeat (10) @(negedge clk);
    end
    wait_pulses(base + 10, 30, ok);
    repeat (5) @(negedge clk);
    checks++; if (valid_count - base != 10) begin errors++; $display("[TB] FAIL countdown_pulses: got %0d, expected 10", valid_count - base); end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    bus.count = 8'd255;
    test_reset();
    test_hundred();
    test_seven();
    test_back_to_back();
    test_reset_mid_conv();
    test_countdown();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_bcd_display.md
# count_bcd_display

Downstream stage for the 8-bit down counter. It consumes the counter's `count` bus, converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives a time-multiplexed 3-digit common-anode 7-segment display with leading-zero blanking. Any change on `count` triggers a new conversion, so the display always tracks the counter without a handshake from it.

## Interface
- `SCAN_DIV`, default 4: clk cycles each digit slot is held; legal range ≥ 2.

- `clk`  input  1  system clock, rising-edge active.
- `reset`  input  1  reset; one clock, reset is asynchronous and active-low.
- `count`  input  8  binary value from the down counter; free-running, no valid strobe.
- `bcd`  output  12  converted value: [11:8] hundreds, [7:4] tens, [3:0] ones.
- `bcd_valid`  output  1  one-cycle pulse when `bcd` has just been updated.
- `busy`  output  1  high while a conversion is in progress.
- `seg`  output  7  segments gfedcba, active-low.
- `an`  output  3  digit enables, active-low: [0] ones, [1] tens, [2] hundreds.

## Operation
- Reset (asynchronous, `reset`=0) forces: `bcd`=12'h000, `last`=8'h00, state IDLE, `bcd_valid`=0, `busy`=0, scan counter 0, digit index 0, `seg`=7'b1111111, `an`=3'b111.
- Converter FSM, states IDLE, CONV:
  - IDLE: if `count` != `last`: capture `count` into the shift register and `last`; clear BCD scratch and shift counter; go to CONV. Otherwise stay.
  - CONV: each cycle, add 3 to every scratch BCD nibble ≥ 5, then shift {scratch, shift register} left by 1. After the 8th shift: write scratch to `bcd`, assert `bcd_valid` for one cycle, return to IDLE.
  - `count` changes during CONV are ignored. On return to IDLE, the current `count` is compared against `last`, so the latest value is always converted eventually. Intermediate values may be skipped.
  - `busy` = (state == CONV).
- Width rule: the 8-bit input never exceeds 255, so the hundreds nibble is at most 2. No overflow handling is required.
- Display scan:
  - The scan counter counts 0..SCAN_DIV-1.
  - On its terminal value, the digit index advances 0 → 1 → 2 → 0 (ones, tens, hundreds).
- Leading-zero blanking:
  - Hundreds slot is blanked if the hundreds digit = 0.
  - Tens slot is blanked if hundreds = 0 and tens = 0.
  - Ones slot is never blanked.
  - A blanked slot drives `an`=3'b111 and `seg`=7'b1111111.
- Unblanked slot:
  - `an` is 3'b110, 3'b101 or 3'b011 for ones, tens or hundreds.
  - `seg` decodes 0..9 as 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - Nibble values 10–15 cannot occur. If they did, they decode to 1111111.
- `seg` and `an` are registered and are derived from the committed `bcd`, never from the scratch register. The display never shows a partial conversion.

## Timing
- Capture edge E0 (IDLE, mismatch). Shifts occur on E1..E8.
- `bcd` is updated on E8. `busy` is high from after E0 until E8, exactly 8 cycles. `bcd_valid` is high for the single cycle after E8.
- The earliest next capture is E9. A back-to-back conversion period is therefore 9 cycles.
- `seg`/`an` lag the digit index and `bcd` by 1 cycle (registered decode).
- A new `bcd` appears on the display no later than 1 + 3·SCAN_DIV cycles after E8.
- Reset mid-conversion aborts immediately. After release, `count` is compared to `last`=0 and is reconverted if nonzero.

## Test plan
- Hold `count`=255 and pulse `reset` low for 2 cycles:
  - During reset: `bcd`=000, `an`=111, `seg`=1111111.
  - After release: `busy` high for exactly 8 cycles, then `bcd`=12'h255 with a single `bcd_valid` pulse.
  - The display cycles `an` 110/101/011 with `seg` 0010010 (5), 0010010 (5), 0100100 (2), each held SCAN_DIV cycles.
- `count`=100:
  - `bcd`=12'h100.
  - Hundreds slot shows `seg` 1111001; tens and ones slots show 1000000. Tens is not blanked.
- `count`=7:
  - `bcd`=12'h007.
  - Hundreds and tens slots drive `an`=111.
  - Ones slot drives `an`=110 with `seg`=1111000.
- Change during conversion: set `count`=200, then 199 two cycles after capture.
  - First pulse with `bcd`=12'h200.
  - Second capture on the next cycle; second pulse 9 cycles after the first, with `bcd`=12'h199.
  - Exactly two pulses in total.
- Assert `reset` during the 4th shift:
  - `busy`=0 and `bcd`=000 immediately, without waiting for a clock edge.
  - After release with `count`=255: full conversion to 12'h255.
- Drive `count` from 255 down by 1 every 10 cycles for 10 steps:
  - 10 `bcd_valid` pulses, with `bcd` values 255, 254, …, 246 in order and none skipped.
